// File: rtl/fx_seq_pkg.sv
// Shared constants and types for the seven-segment effect step sequencer.
package fx_seq_pkg;

  localparam int COUNT_W = 3;
  localparam logic [COUNT_W-1:0] COUNT_MIN = 3'd0;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 3'd7;

  typedef enum logic [1:0] {
    SPD_1X = 2'd0,
    SPD_2X = 2'd1,
    SPD_4X = 2'd2,
    SPD_8X = 2'd3
  } spd_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/fx_prescaler.sv
// Programmable step-rate prescaler: counts running cycles and raises tick
// when the count reaches the speed-dependent terminal value.
module fx_prescaler
  import fx_seq_pkg::*;
#(
  parameter int DIV_WIDTH = 24,
  parameter int BASE_DIV  = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       sync,
  input  logic [1:0] speed,
  output logic       tick
);

  // One extra bit so BASE_DIV == 2**DIV_WIDTH is representable.
  localparam logic [DIV_WIDTH:0] BASE_W = (DIV_WIDTH+1)'(BASE_DIV);

  spd_e                 spd;
  logic [DIV_WIDTH:0]   term_full;
  logic [DIV_WIDTH-1:0] term;
  logic [DIV_WIDTH-1:0] cnt_q;

  assign spd       = spd_e'(speed);
  assign term_full = (BASE_W >> spd) - (DIV_WIDTH+1)'(1);
  assign term      = DIV_WIDTH'(term_full);

  // >= so a speed increase never forces a full wrap of the counter.
  assign tick = run && !sync && (cnt_q >= term);

  always_ff @(posedge clk) begin
    if (rst || sync) begin
      cnt_q <= '0;
    end else if (run) begin
      if (cnt_q >= term) cnt_q <= '0;
      else               cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fx_step_sequencer.sv
// Animation index sequencer (0..7) with step/wrap strobes.
// Optional ping-pong mode is enabled by defining FX_PINGPONG_EN.
module fx_step_sequencer
  import fx_seq_pkg::*;
#(
  parameter int DIV_WIDTH = 24,
  parameter int BASE_DIV  = 12_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_dir,
  input  logic [1:0]         i_speed,
  input  logic               i_sync,
`ifdef FX_PINGPONG_EN
  input  logic               i_bounce,
`endif
  output logic [COUNT_W-1:0] o_count,
  output logic               o_step,
  output logic               o_wrap
);

  logic               tick;
  logic [COUNT_W-1:0] count_q, count_n;
  logic               dir_q, dir_n;
  logic               step_q, step_n;
  logic               wrap_q, wrap_n;
`ifdef FX_PINGPONG_EN
  logic               eff_dir;
`endif

  fx_prescaler #(
    .DIV_WIDTH (DIV_WIDTH),
    .BASE_DIV  (BASE_DIV)
  ) u_prescaler (
    .clk   (i_clk),
    .rst   (i_rst),
    .run   (i_run),
    .sync  (i_sync),
    .speed (i_speed),
    .tick  (tick)
  );

  always_comb begin
    count_n = count_q;
    dir_n   = dir_q;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
`ifdef FX_PINGPONG_EN
    eff_dir = dir_q;
`endif
    if (i_sync) begin
      count_n = (i_dir == DIR_REV) ? COUNT_MAX : COUNT_MIN;
      dir_n   = i_dir;
    end else if (tick) begin
      step_n = 1'b1;
`ifdef FX_PINGPONG_EN
      if (i_bounce) begin
        // At an end the only legal move is inward, whatever the flag says.
        if (count_q == COUNT_MAX)      eff_dir = DIR_REV;
        else if (count_q == COUNT_MIN) eff_dir = DIR_FWD;
        count_n = (eff_dir == DIR_REV) ? count_q - 3'd1 : count_q + 3'd1;
        dir_n   = eff_dir;
        if (count_n == COUNT_MAX) dir_n = DIR_REV;
        if (count_n == COUNT_MIN) dir_n = DIR_FWD;
        wrap_n  = (count_n == COUNT_MAX) || (count_n == COUNT_MIN);
      end else begin
        dir_n   = i_dir;
        count_n = (i_dir == DIR_REV) ? count_q - 3'd1 : count_q + 3'd1;
        wrap_n  = (i_dir == DIR_REV) ? (count_q == COUNT_MIN) : (count_q == COUNT_MAX);
      end
`else
      dir_n   = i_dir;
      count_n = (i_dir == DIR_REV) ? count_q - 3'd1 : count_q + 3'd1;
      wrap_n  = (i_dir == DIR_REV) ? (count_q == COUNT_MIN) : (count_q == COUNT_MAX);
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= COUNT_MIN;
      dir_q   <= DIR_FWD;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_n;
      dir_q   <= dir_n;
      step_q  <= step_n;
      wrap_q  <= wrap_n;
    end
  end

  assign o_count = count_q;
  assign o_step  = step_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_fx_step_sequencer.sv
// Scoreboard bench for fx_step_sequencer (BASE_DIV=8); exercises ping-pong
// mode too when built with FX_PINGPONG_EN.
module tb_fx_step_sequencer;

  localparam int W = 21; // {cycle[15:0], count[2:0], step, wrap}

  logic       clk = 1'b0;
  logic       rst, run, dir, sync, bounce;
  logic [1:0] speed;
  logic [2:0] o_count;
  logic       o_step, o_wrap;

  always #5 clk = ~clk;

  fx_step_sequencer #(
    .DIV_WIDTH (4),
    .BASE_DIV  (8)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_run   (run),
    .i_dir   (dir),
    .i_speed (speed),
    .i_sync  (sync),
`ifdef FX_PINGPONG_EN
    .i_bounce(bounce),
`endif
    .o_count (o_count),
    .o_step  (o_step),
    .o_wrap  (o_wrap)
  );

  int unsigned  cyc = 0;
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           mon_en   = 0;
  logic [2:0]   prev_count;

  // Reference model state
  int m_pre, m_cnt;
  bit m_dir;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got cyc=%0d cnt=%0d step=%0b wrap=%0b, expected cyc=%0d cnt=%0d step=%0b wrap=%0b",
                  name, act[20:5], act[4:2], act[1], act[0], exp[20:5], exp[4:2], exp[1], exp[0]);
  endfunction

  // Spec-level model: prescaler as an integer, index as arithmetic mod 8.
  task automatic model_step();
    int term, old;
    bit st, wr;
    logic [15:0] tag;
    term = (8 >> speed) - 1;
    old  = m_cnt;
    st   = 0;
    wr   = 0;
    if (rst) begin
      m_pre = 0; m_cnt = 0; m_dir = 0;
    end else if (sync) begin
      m_pre = 0; m_cnt = dir ? 7 : 0; m_dir = dir;
    end else if (run) begin
      if (m_pre >= term) begin
        m_pre = 0;
        st    = 1;
        if (bounce) begin
          if (m_cnt == 7) m_dir = 1;
          else if (m_cnt == 0) m_dir = 0;
          m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
          wr    = (m_cnt == 0) || (m_cnt == 7);
        end else begin
          m_dir = dir;
          m_cnt = (m_cnt + (dir ? 7 : 1)) % 8;
          wr    = dir ? (old == 0) : (old == 7);
        end
      end else begin
        m_pre++;
      end
    end
    if (mon_en && (st || wr || m_cnt != old)) begin
      tag = 16'(cyc + 1);
      exp_q.push_back({tag, 3'(m_cnt), st, wr});
    end
  endtask

  task automatic drive(input bit r, input bit rn, input bit d, input logic [1:0] s, input bit sy);
    @(negedge clk);
    rst = r; run = rn; dir = d; speed = s; sync = sy;
    model_step();
  endtask

  // Monitor: any visible output activity pops one expected event.
  always @(posedge clk) begin
    logic [W-1:0] act;
    #1;
    if (mon_en && (o_step || o_wrap || o_count !== prev_count)) begin
      act = {cyc[15:0], o_count, o_step, o_wrap};
      if (exp_q.size() == 0) check("unexpected_event", act, '0);
      else check("event", act, exp_q.pop_front());
    end
    prev_count = o_count;
  end

  initial begin
    bit d;
    logic [1:0] s;
    rst = 1; run = 0; dir = 0; speed = 0; sync = 0;
`ifdef FX_PINGPONG_EN
    bounce = 0;
`else
    bounce = 0;
`endif
    repeat (3) @(negedge clk);
    check("reset_count", W'(o_count), W'(0));
    check("reset_step",  W'(o_step),  W'(0));
    check("reset_wrap",  W'(o_wrap),  W'(0));
    m_pre = 0; m_cnt = 0; m_dir = 0;
    mon_en = 1;

    // Forward run at speed 0: full cycle plus wrap.
    repeat (72) drive(0, 1, 0, 2'd0, 0);
    // Sync into reverse, then run through 0->7.
    drive(0, 1, 1, 2'd0, 1);
    repeat (72) drive(0, 1, 1, 2'd0, 0);
    // Pause mid-period at count 3.
    drive(0, 1, 0, 2'd0, 1);
    for (int i = 0; i < 100 && m_cnt != 3; i++) drive(0, 1, 0, 2'd0, 0);
    repeat (3) drive(0, 1, 0, 2'd0, 0);
    repeat (20) drive(0, 0, 0, 2'd0, 0);
    repeat (20) drive(0, 1, 0, 2'd0, 0);
    // Speed change with prescaler already past the new terminal value.
    for (int i = 0; i < 20 && m_pre != 5; i++) drive(0, 1, 0, 2'd0, 0);
    repeat (12) drive(0, 1, 0, 2'd2, 0);
    repeat (12) drive(0, 1, 0, 2'd3, 0);
    // Direction flip at count 4.
    for (int i = 0; i < 100 && m_cnt != 4; i++) drive(0, 1, 0, 2'd0, 0);
    repeat (20) drive(0, 1, 1, 2'd0, 0);
    // Reset mid-period then resume.
    repeat (3) drive(0, 1, 0, 2'd0, 0);
    drive(1, 1, 0, 2'd0, 0);
    repeat (20) drive(0, 1, 0, 2'd0, 0);

`ifdef FX_PINGPONG_EN
    bounce = 1;
    drive(0, 1, 0, 2'd3, 1);
    repeat (30) drive(0, 1, 0, 2'd3, 0);
    repeat (5)  drive(0, 1, 1, 2'd1, 0);
    drive(1, 1, 0, 2'd3, 0);
    repeat (20) drive(0, 1, 1, 2'd3, 0);
`endif

    // Randomised traffic.
    d = 0; s = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) d = ~d;
      if ($urandom_range(0, 39) == 0) s = 2'($urandom_range(0, 3));
`ifdef FX_PINGPONG_EN
      if ($urandom_range(0, 99) == 0) bounce = ~bounce;
`endif
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, d, s,
            $urandom_range(0, 99) == 0);
    end

    repeat (4) drive(0, 0, 0, 2'd0, 0);
    @(negedge clk);
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
